// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage ahead of the control unit. Owns the program counter, issues
//   reads to a 1-cycle-latency synchronous program memory, buffers returned
//   instructions (with their fetch PC) in a 2-entry FIFO and presents the
//   head on a valid/ready handshake. Supports PC redirect with queue flush.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fetch_en                 allow new reads
//   pc_load, pc_load_addr    redirect strobe and target
//   mem_en, mem_addr         program memory read request
//   mem_data                 read data, valid the cycle after mem_en
//   instr_out, instr_pc      queue head instruction and its address
//   instr_valid, instr_ready head handshake
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_addr,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               infl_q;
  logic [ADDR_W-1:0]  infl_pc_q, infl_pc_d;
  entry_t             e0_q, e1_q, e0_d, e1_d;
  logic [1:0]         cnt_q, cnt_d;

  logic               pop, push, issue;
  logic [2:0]         occ;
  entry_t             ret_entry;

  assign instr_valid = (cnt_q != 2'd0);
  assign instr_out   = e0_q.instr;
  assign instr_pc    = e0_q.pc;
  assign pop         = instr_valid & instr_ready;

  // Slots committed after this cycle: queued + returning - leaving.
  assign occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue = !rst && fetch_en && (state_q == RUN) && !pc_load && (occ < 3'd2);

  // A return coinciding with pc_load is the stale read and is dropped. With
  // 1-cycle latency nothing can be in flight during REDIRECT, the state check
  // just keeps that airtight.
  assign push      = infl_q && (state_q == RUN) && !pc_load;
  assign ret_entry = '{instr: mem_data, pc: infl_pc_q};

  assign mem_en   = issue;
  assign mem_addr = rst ? RESET_PC : pc_q;

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (pc_load)                  state_d = REDIRECT;
    else if (state_q == REDIRECT) state_d = RUN;
  end

  // PC and request tracking
  always_comb begin
    pc_d      = pc_q;
    infl_pc_d = infl_pc_q;
    if (pc_load) begin
      pc_d = pc_load_addr;
    end else if (issue) begin
      pc_d      = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      infl_pc_d = pc_q;
    end
  end

  // Queue: apply pop first, then push into the first free slot.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) e0_d = ret_entry;
      else               e1_d = ret_entry;
      cnt_d = cnt_d + 2'd1;
    end
    if (pc_load) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      e0_q      <= '0;
      e1_q      <= '0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= issue;
      infl_pc_q <= infl_pc_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: program memory model, queue-based
// behavioural reference checked every cycle, plus directed scenarios with
// literal expectations.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_en = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_addr = 8'h00;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [7:0] instr; logic [7:0] pc; } ent_t;

  // Reference: a queue of what must be visible, the PC of the next fetch, and
  // whether one read is outstanding. Redirect costs one dead cycle.
  ent_t       mq[$];
  logic [7:0] m_pc = 8'h00;
  bit         m_infl = 1'b0;
  logic [7:0] m_infl_pc = 8'h00;
  bit         m_redir = 1'b0;
  ent_t       dlv[$];

  always @(negedge clk) begin : model
    bit   pop, ex_issue;
    int   occ;
    ent_t e;
    pop      = (mq.size() > 0) && instr_ready;
    occ      = mq.size() + int'(m_infl) - int'(pop);
    ex_issue = !rst && fetch_en && !m_redir && !pc_load && (occ < 2);
    chk("mem_en", mem_en, ex_issue);
    if (ex_issue || rst) chk("mem_addr", mem_addr, rst ? 8'h00 : m_pc);
    chk("instr_valid", instr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("instr_out", instr_out, mq[0].instr);
      chk("instr_pc", instr_pc, mq[0].pc);
    end
    if (!rst && instr_valid && instr_ready) dlv.push_back('{instr_out, instr_pc});
    if (rst) begin
      mq.delete();
      m_pc = 8'h00; m_infl = 1'b0; m_redir = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (pc_load) begin
        mq.delete();
        m_pc = pc_load_addr; m_infl = 1'b0; m_redir = 1'b1;
      end else begin
        if (m_infl && !m_redir) begin
          if (mq.size() >= 2) chk("queue_overflow", mq.size(), 1);
          e.instr = mem[m_infl_pc];
          e.pc    = m_infl_pc;
          mq.push_back(e);
        end
        m_redir = 1'b0;
        m_infl  = ex_issue;
        if (ex_issue) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 8'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input int n);
    repeat (n) tick();
  endtask

  // Two reset cycles; returns in cycle 0 (first cycle with rst low).
  task automatic start(input bit chk_reset);
    rst = 1'b1; pc_load = 1'b0;
    tick();
    if (chk_reset) begin
      #1;
      chk("rst_valid", instr_valid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_instr_out", instr_out, 8'h00);
      chk("rst_instr_pc", instr_pc, 8'h00);
    end
    tick();
    rst = 1'b0;
    dlv.delete();
  endtask

  int cnt;
  int issued;
  logic [31:0] fe_pat, rd_pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);

    // T1: latency and streaming
    fetch_en = 1'b1; instr_ready = 1'b1;
    start(1'b1);
    #1;
    chk("t1_c0_mem_en", mem_en, 1);
    chk("t1_c0_mem_addr", mem_addr, 8'h00);
    tick(); chk("t1_c1_valid", instr_valid, 0);
    tick(); chk("t1_c2_valid", instr_valid, 1); chk("t1_c2_out", instr_out, 8'h10); chk("t1_c2_pc", instr_pc, 8'h00);
    tick(); chk("t1_c3_out", instr_out, 8'h11); chk("t1_c3_pc", instr_pc, 8'h01);
    tick(); chk("t1_c4_out", instr_out, 8'h12); chk("t1_c4_pc", instr_pc, 8'h02);

    // T2: back-pressure
    instr_ready = 1'b0;
    start(1'b0);
    cnt = 0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      #1;
      cnt += int'(mem_en);
      if (c >= 2) chk("t2_head_stable", instr_out, 8'h10);
    end
    chk("t2_reads_issued", cnt, 2);
    tick(); instr_ready = 1'b1;
    go(4);
    chk("t2_len", dlv.size() >= 3, 1);
    chk("t2_d0", dlv[0].instr, 8'h10);
    chk("t2_d1", dlv[1].instr, 8'h11);
    chk("t2_d2", dlv[2].instr, 8'h12);

    // T3: redirect while address 5 is returning
    start(1'b0);
    go(6);
    pc_load = 1'b1; pc_load_addr = 8'h40;
    tick(); pc_load = 1'b0;
    chk("t3_gap1_valid", instr_valid, 0);
    tick(); chk("t3_gap2_valid", instr_valid, 0);
    go(6);
    cnt = 0;
    foreach (dlv[i]) if (dlv[i].pc == 8'h05) cnt++;
    chk("t3_no_pc5", cnt, 0);
    chk("t3_len", dlv.size() >= 6, 1);
    chk("t3_last_old_pc", dlv[4].pc, 8'h04);
    chk("t3_target_pc", dlv[5].pc, 8'h40);
    chk("t3_target_instr", dlv[5].instr, 8'h50);

    // T4: redirect near the top of the address space
    start(1'b0);
    pc_load = 1'b1; pc_load_addr = 8'hFE;
    tick(); pc_load = 1'b0;
    go(8);
    chk("t4_len", dlv.size() >= 4, 1);
    chk("t4_pc0", dlv[0].pc, 8'hFE); chk("t4_i0", dlv[0].instr, 8'h0E);
    chk("t4_pc1", dlv[1].pc, 8'hFF); chk("t4_i1", dlv[1].instr, 8'h0F);
    chk("t4_pc2", dlv[2].pc, 8'h00); chk("t4_i2", dlv[2].instr, 8'h10);
    chk("t4_pc3", dlv[3].pc, 8'h01); chk("t4_i3", dlv[3].instr, 8'h11);

    // T5: pop and pc_load together with a full queue
    instr_ready = 1'b0;
    start(1'b0);
    go(5);
    instr_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 8'h80;
    tick(); pc_load = 1'b0;
    go(6);
    chk("t5_len", dlv.size() >= 2, 1);
    chk("t5_popped_pc", dlv[0].pc, 8'h00);
    chk("t5_popped_instr", dlv[0].instr, 8'h10);
    chk("t5_next_pc", dlv[1].pc, 8'h80);
    chk("t5_next_instr", dlv[1].instr, 8'h90);

    // T6: reset mid-stream with data queued and a read outstanding
    start(1'b0);
    go(4);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    chk("t6_valid", instr_valid, 0);
    chk("t6_mem_addr", mem_addr, 8'h00);
    chk("t6_mem_en", mem_en, 1);
    tick(); chk("t6_c1_valid", instr_valid, 0);
    tick(); chk("t6_c2_out", instr_out, 8'h10); chk("t6_c2_pc", instr_pc, 8'h00);
    tick(); chk("t6_c3_out", instr_out, 8'h11); chk("t6_c3_pc", instr_pc, 8'h01);

    // T7: fetch_en / ready interleaving, then drain with fetch disabled
    fe_pat = 32'b0011_1111_1100_0111_1110_0111_1111_1111;
    rd_pat = 32'b1011_0011_1100_0110_1110_0001_1111_0110;
    start(1'b0);
    issued = 0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) tick();
      fetch_en = fe_pat[c]; instr_ready = rd_pat[c];
      #1;
      issued += int'(mem_en);
    end
    tick(); fetch_en = 1'b0; instr_ready = 1'b1;
    go(5);
    chk("t7_none_lost", dlv.size(), issued);
    cnt = 0;
    foreach (dlv[i]) if (dlv[i].pc != 8'(i)) cnt++;
    chk("t7_in_order", cnt, 0);
    chk("t7_drained", instr_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
